// File: rtl/sync_pkg.sv
// Shared types and default widths for the sync block (buffer, detector, reader).
package sync_pkg;
  localparam int SYNC_DATA_W = 24;
  localparam int SYNC_ADDR_W = 14;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} rd_state_t;
endpackage

// File: rtl/sync_skid_fifo.sv
// Two-entry FIFO that absorbs the buffer read latency against downstream stalls.
// Slot 0 is always the head, so head data holds steady until it is popped.
module sync_skid_fifo #(
  parameter int DATA_W = 24
) (
  input  logic              iclk,
  input  logic              irst,
  input  logic              ipush,
  input  logic [DATA_W-1:0] ipush_data,
  input  logic              ipush_last,
  input  logic              ipop,
  output logic [1:0]        ocount,
  output logic [DATA_W-1:0] ohead_data,
  output logic              ohead_last
);
  logic [DATA_W-1:0] data_reg [2];
  logic              last_reg [2];
  logic [1:0]        count_reg;
  logic [1:0]        wr_slot;

  // Push lands in the first slot left free after this cycle's pop.
  assign wr_slot = count_reg - {1'b0, ipop};

  always_ff @(posedge iclk) begin
    if (irst) begin
      count_reg   <= '0;
      data_reg[0] <= '0;
      data_reg[1] <= '0;
      last_reg[0] <= 1'b0;
      last_reg[1] <= 1'b0;
    end else begin
      count_reg <= count_reg + {1'b0, ipush} - {1'b0, ipop};
      if (ipop) begin
        data_reg[0] <= data_reg[1];
        last_reg[0] <= last_reg[1];
      end
      if (ipush) begin
        if (wr_slot == 2'd0) begin
          data_reg[0] <= ipush_data;
          last_reg[0] <= ipush_last;
        end else begin
          data_reg[1] <= ipush_data;
          last_reg[1] <= ipush_last;
        end
      end
    end
  end

  assign ocount     = count_reg;
  assign ohead_data = data_reg[0];
  assign ohead_last = last_reg[0];
endmodule

// File: rtl/sync_frame_reader.sv
// Walks the sample buffer read port from a detected frame start and streams the
// frame out as valid/ready words, never reading at or past the writer pointer.
module sync_frame_reader
  import sync_pkg::*;
#(
  parameter int DATA_W = SYNC_DATA_W,
  parameter int ADDR_W = SYNC_ADDR_W
) (
  input  logic              iclk,
  input  logic              irst,
  input  logic              istart,
  input  logic [ADDR_W-1:0] istart_addr,
  input  logic [ADDR_W-1:0] ilen,
  input  logic [ADDR_W-1:0] iwr_addr,
  output logic [ADDR_W-1:0] or_addr,
  input  logic [DATA_W-1:0] iram_data,
  output logic [DATA_W-1:0] odata,
  output logic              ovalid,
  input  logic              iready,
  output logic              olast,
  output logic              obusy,
  output logic              odone
);
  rd_state_t         state_reg;
  logic [ADDR_W-1:0] rd_ptr_reg;
  logic [ADDR_W-1:0] remain_reg;
  logic              inflight_reg;
  logic              inflight_last_reg;
  logic              odone_reg;
  logic              obusy_reg;
  logic [1:0]        fifo_count;
  logic              pop;
  logic              issue;
  logic [2:0]        occupancy;

  assign pop       = ovalid & iready;
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_reg} - {2'b00, pop};
  assign issue     = (state_reg == RUN) && (remain_reg != '0) &&
                     (rd_ptr_reg != iwr_addr) && (occupancy < 3'd2);

  always_ff @(posedge iclk) begin
    if (irst) begin
      state_reg         <= IDLE;
      rd_ptr_reg        <= '0;
      remain_reg        <= '0;
      inflight_reg      <= 1'b0;
      inflight_last_reg <= 1'b0;
      odone_reg         <= 1'b0;
      obusy_reg         <= 1'b0;
    end else begin
      odone_reg         <= 1'b0;
      inflight_reg      <= issue;
      inflight_last_reg <= issue && (remain_reg == ADDR_W'(1));
      if (issue) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
        remain_reg <= remain_reg - 1'b1;
      end
      case (state_reg)
        IDLE: begin
          // obusy lingers one cycle past the DRAIN exit so it falls after odone.
          obusy_reg <= 1'b0;
          if (istart) begin
            rd_ptr_reg <= istart_addr;
            remain_reg <= ilen;
            if (ilen == '0) begin
              odone_reg <= 1'b1;
            end else begin
              state_reg <= RUN;
              obusy_reg <= 1'b1;
            end
          end
        end
        RUN: begin
          if (issue && (remain_reg == ADDR_W'(1))) state_reg <= DRAIN;
        end
        DRAIN: begin
          if (!inflight_reg &&
              ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop))) begin
            odone_reg <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  sync_skid_fifo #(.DATA_W(DATA_W)) u_fifo (
    .iclk      (iclk),
    .irst      (irst),
    .ipush     (inflight_reg),
    .ipush_data(iram_data),
    .ipush_last(inflight_last_reg),
    .ipop      (pop),
    .ocount    (fifo_count),
    .ohead_data(odata),
    .ohead_last(olast)
  );

  assign ovalid  = (fifo_count != 2'd0);
  assign or_addr = rd_ptr_reg;
  assign obusy   = obusy_reg;
  assign odone   = odone_reg;
endmodule

// File: doc/sync_frame_reader.md
# sync_frame_reader

Read-side controller for the sync block's dual-port sample buffer. Once the sync detector reports a frame start address and length, it walks the buffer's read port from that address and emits the frame as a valid/ready stream with `olast` on the final word. It never overtakes the writer and absorbs the buffer's one-cycle read latency plus downstream backpressure with no lost or duplicated samples.

## Interface
- `DATA_W`, 24: sample word width, equal to the buffer's data width.
- `ADDR_W`, 14: buffer address width; depth is 2**ADDR_W.

Ports:
- `iclk`, in, 1: single clock for the block and the buffer.
- `irst`, in, 1: reset. Synchronous and active-high.
- `istart`, in, 1: one-cycle start pulse. Honoured only in IDLE.
- `istart_addr`, in, ADDR_W: buffer address of the first frame word. Sampled with `istart`.
- `ilen`, in, ADDR_W: frame length in words. Sampled with `istart`.
- `iwr_addr`, in, ADDR_W: writer's next-write address. Words up to `iwr_addr-1` (mod depth) are valid.
- `or_addr`, out, ADDR_W: buffer read address.
- `iram_data`, in, DATA_W: buffer read data, valid one cycle after `or_addr`.
- `odata`, out, DATA_W: stream data.
- `ovalid`, out, 1: stream valid.
- `iready`, in, 1: stream ready.
- `olast`, out, 1: marks the final frame word; qualified by `ovalid`.
- `obusy`, out, 1: high whenever the block is not in IDLE.
- `odone`, out, 1: one-cycle pulse when the frame is complete.

## Operation
States: IDLE, RUN, DRAIN.

- **IDLE**
  - On `istart`: latch `rd_ptr=istart_addr` and `remain=ilen`.
  - If `ilen==0`: pulse `odone` next cycle and stay in IDLE.
  - Otherwise go to RUN.
- **RUN**
  - Issue a read when all of these hold: `remain>0`, `rd_ptr!=iwr_addr`, and `fifo_count + inflight - pop < 2`, where `pop = ovalid & iready` in the same cycle.
  - On issue: `or_addr<=rd_ptr`, `rd_ptr+1` (wraps from 2**ADDR_W-1 to 0), `remain-1`, and `inflight` is set for the next cycle.
  - When the issue takes `remain` to 0, go to DRAIN.
- **DRAIN**
  - When the FIFO is empty, nothing is in flight, and no data is arriving, pulse `odone` and go to IDLE.
- **Read-data capture**
  - Each in-flight read's `iram_data` is pushed into the 2-entry FIFO the cycle after issue.
  - The FIFO head drives `odata`/`ovalid`.
  - The word pushed on the issue that took `remain` to 0 carries the last flag and drives `olast`.
- **Stream rules**
  - While `ovalid` is high and `iready` is low, `odata`/`olast` hold stable.
  - `ovalid` never drops without a transfer.
- **Writer pointer**
  - `rd_ptr==iwr_addr` means the buffer is empty and stalls issue.
  - Distance is computed mod 2**ADDR_W. The writer lapping the reader is the writer's responsibility and is not detected.
- **Other events**
  - `istart` in RUN or DRAIN is ignored.
  - `irst` at any time returns the block to IDLE, flushes the FIFO and inflight, and forces all outputs to reset values the next cycle.

## Timing
- Reset values: `or_addr=0`, `odata=0`, `ovalid=0`, `olast=0`, `obusy=0`, `odone=0`.
- `istart` in cycle 0 gives, with data available:
  - cycle 1: `obusy=1` and the first `or_addr` driven;
  - cycle 2: `iram_data` captured;
  - cycle 3: `ovalid=1`.
- With `iready` held high and the writer ahead, throughput is one word per cycle.
- Cycle 3 is the earliest possible `ovalid`. An N-word frame has its last transfer in cycle N+2 and `odone` in cycle N+3; `obusy` falls in cycle N+4.
- `odone` is registered and exactly one cycle wide.
- `ilen==0` case: `odone` in cycle 1, `obusy` stays 0.
- Issue gating uses the current-cycle `pop`. The FIFO never exceeds 2 entries and never overflows.

## Structure
- Package `sync_pkg`:
  - `rd_state_t` enum {IDLE, RUN, DRAIN};
  - default `DATA_W`/`ADDR_W` localparams shared with the buffer and detector.
- Sub-module `sync_skid_fifo`: 2-entry FIFO with push/pop, `count`, and head data plus last flag. Parameterised by `DATA_W`.
- Top-level: FSM, `rd_ptr`/`remain` counters, inflight flag, issue logic.

## Test plan
- **Basic frame:** `iwr_addr=100`, `istart` with `addr=10`, `len=4`, `iready=1` -> `odata` = ram[10..13] on 4 consecutive cycles from cycle 3; `olast` on ram[13]; `odone` in cycle 7.
- **Wrap-around:** `ADDR_W=14`, `addr=16382`, `len=4`, `iwr_addr=10` -> `or_addr` sequence 16382, 16383, 0, 1; data in order.
- **Writer stall:** `addr=50`, `len=8`, `iwr_addr=53`, then `iwr_addr` stepped by 1 every 5 cycles -> only words 50–52 issued until `iwr_addr` advances; no read of an unwritten address; 8 words total.
- **Backpressure:** `len=16`, `iready` toggles 1/0 pseudo-randomly with ~30% low -> all 16 words delivered in order, no duplicates; `odata` stable while stalled; FIFO count ≤ 2.
- **Zero length and busy start:** `len=0` -> `odone` in cycle 1, `ovalid` never high. `istart` mid-frame -> ignored; frame completes unchanged.
- **Reset mid-frame:** `irst` in RUN after 3 transfers -> next cycle all outputs at reset values and state IDLE; a new `istart` then runs a clean frame.
